// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared result encodings and FSM state type for the sequential comparator
// Contents:
//   CMP_GT / CMP_EQ / CMP_LT : one-hot {gt, eq, lt} result codes
//   cmp_state_t              : IDLE, CMP, DONE
package cmp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/nibble_cmp_msb.sv
// rtl/nibble_cmp_msb.sv - combinational unsigned compare of one 4-bit digit
// Ports:
//   a, b   : 4-bit digits (caller pre-inverts bit 3 for a signed MSB digit)
//   result : one-hot {gt, eq, lt}
module nibble_cmp_msb
    import cmp_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [2:0] result
);

    always_comb begin
        result = CMP_EQ;
        if (a > b) begin
            result = CMP_GT;
        end else if (a < b) begin
            result = CMP_LT;
        end
    end

endmodule

// File: rtl/seq_compare_32.sv
// rtl/seq_compare_32.sv - digit-serial magnitude comparator, MSB digit first
// Build option: SEQ_COMPARE_SIGNED_EN enables two's-complement compare via is_signed.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : compare request, accepted in IDLE or DONE
//   a, b         : operands (4*NIBBLES bits), latched on accepted start
//   is_signed    : signed compare request, latched with a/b (ignored without the build option)
//   busy         : high while digits are being compared
//   done         : one-cycle pulse, result valid
//   result       : one-hot {gt, eq, lt}, held until the next compare completes
module seq_compare_32 #(
    parameter int NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           result
);

    import cmp_pkg::*;

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NIBBLES - 1);

    cmp_state_t       state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx;

    logic [3:0]       dig_a_raw;
    logic [3:0]       dig_b_raw;
    logic [3:0]       dig_a;
    logic [3:0]       dig_b;
    logic [2:0]       dig_res;
    logic             flip;

`ifdef SEQ_COMPARE_SIGNED_EN
    logic             sgn_q;
    // Inverting the sign bit of the top digit maps two's-complement order onto unsigned order.
    assign flip = sgn_q && (idx == IDX_MSB);
`else
    logic             is_signed_unused;
    assign is_signed_unused = is_signed;
    assign flip = 1'b0;
`endif

    // Digit mux selected by the down-counting index.
    always_comb begin
        dig_a_raw = 4'h0;
        dig_b_raw = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                dig_a_raw = a_q[i*4 +: 4];
                dig_b_raw = b_q[i*4 +: 4];
            end
        end
    end

    assign dig_a = {dig_a_raw[3] ^ flip, dig_a_raw[2:0]};
    assign dig_b = {dig_b_raw[3] ^ flip, dig_b_raw[2:0]};

    nibble_cmp_msb u_nibble_cmp_msb (
        .a      (dig_a),
        .b      (dig_b),
        .result (dig_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= CMP_EQ;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
`ifdef SEQ_COMPARE_SIGNED_EN
            sgn_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
`ifdef SEQ_COMPARE_SIGNED_EN
                        sgn_q <= is_signed;
`endif
                        idx   <= IDX_MSB;
                        state <= CMP;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CMP: begin
                    // start is deliberately not looked at here.
                    // A differing digit decides; an equal digit at index 0 means full equality.
                    if (dig_res != CMP_EQ || idx == '0) begin
                        result <= dig_res;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_compare_32.sv
// tb/tb_seq_compare_32.sv - randomized self-checking bench for seq_compare_32
module tb_seq_compare_32;

`ifdef SEQ_COMPARE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [2:0]  result;

    int errors = 0;
    int checks = 0;
    logic [2:0] last_res;
    bit launched;

    seq_compare_32 #(.NIBBLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: ordering by integer arithmetic, latency by counting equal leading digits.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [2:0] r, output int k);
        bit sg;
        int eq;
        sg = s & SIGNED_EN;
        if (sg ? ($signed(x) > $signed(y)) : (x > y)) r = 3'b100;
        else if (x == y)                               r = 3'b010;
        else                                           r = 3'b001;
        eq = 0;
        for (int i = 7; i >= 0; i--) begin
            if (((x >> (i * 4)) & 32'hF) == ((y >> (i * 4)) & 32'hF)) eq++;
            else break;
        end
        k = (eq + 1 > 8) ? 8 : eq + 1;
    endtask

    // Called at a negedge. poke>=0 pulses start with junk at that sample (mid-compare).
    // chain=1 drives the next operation's start in the DONE cycle.
    task automatic op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                      input int poke, input bit chain,
                      input logic [31:0] na, input logic [31:0] nb, input logic ns);
        logic [2:0] er;
        int ek;
        int lat;
        int bcnt;
        model(ta, tbv, ts, er, ek);
        if (!launched) begin
            a = ta; b = tbv; is_signed = ts; start = 1'b1;
        end
        launched = 1'b0;
        @(negedge clk);
        a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
        lat = 0;
        bcnt = 0;
        while (lat < 20) begin
            start = 1'b0;
            if (busy) begin
                bcnt++;
                check("result_hold", {29'd0, result}, {29'd0, last_res});
            end
            if (done) break;
            if (lat == poke) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", lat, ek);
        check("busy_cycles", bcnt, ek);
        check("result", {29'd0, result}, {29'd0, er});
        last_res = er;
        if (chain) begin
            a = na; b = nb; is_signed = ns; start = 1'b1;
            launched = 1'b1;
        end else begin
            start = 1'b0;
            @(negedge clk);
            check("done_pulse_end", {31'd0, done}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_result", {29'd0, result}, {29'd0, last_res});
        end
    endtask

    initial begin
        int dcnt;
        logic [31:0] ra, rb, mask, na, nb;
        int sh;
        launched = 1'b0;
        last_res = 3'b010;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {29'd0, result}, 32'd2);
        rst_n = 1'b1;
        @(negedge clk);

        op(32'h12345678, 32'h02345678, 1'b0, -1, 1'b0, 0, 0, 1'b0);
        op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, -1, 1'b0, 0, 0, 1'b0);
        op(32'hFFFFFFFF, 32'h00000001, 1'b1, -1, 1'b0, 0, 0, 1'b0);
        check("signed_expect", {29'd0, last_res}, SIGNED_EN ? 32'd1 : 32'd4);
        op(32'h00000010, 32'h00000011, 1'b0, 3, 1'b0, 0, 0, 1'b0);

        // Reset in the middle of an 8-cycle compare.
        a = 32'hCAFEF00D; b = 32'hCAFEF00D; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", {29'd0, result}, 32'd2);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 3'b010;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("no_done_after_abort", dcnt, 0);

        // Back-to-back: start in the DONE cycle.
        op(32'h80000000, 32'h7FFFFFFF, 1'b0, -1, 1'b1, 32'h0000ABCD, 32'h0000ABCE, 1'b0);
        op(32'h0000ABCD, 32'h0000ABCE, 1'b0, -1, 1'b1, 32'h55555555, 32'h55555555, 1'b0);
        op(32'h55555555, 32'h55555555, 1'b0, -1, 1'b0, 0, 0, 1'b0);

        // Random operands sharing a random number of leading bits.
        na = $urandom;
        for (int n = 0; n < 30; n++) begin
            ra = na;
            sh = $urandom_range(0, 32);
            mask = (sh == 32) ? 32'd0 : (32'hFFFFFFFF >> sh);
            rb = ra ^ ($urandom & mask);
            na = $urandom;
            nb = 32'd0;
            op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : -1,
               1'b0, nb, nb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
